usb_protocol: RTL and testbench
===============================

# usb_protocol

Host-side USB transaction engine sitting directly upstream of the `pipeOut` transmit pipeline and downstream of the `pipeIn` receive pipeline. It accepts one OUT (write) or IN (read) transaction request, sequences the token, DATA0 and handshake packets, and times out silent devices. It retries failed attempts and reports completion, success flag and read data to the layer above.

## Interface

Parameters:

- `MAX_RETRY`, default 8: total attempts per transaction before reporting failure.
- `TIMEOUT`, default 255: idle cycles allowed for a device response.

Ports:

- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_L` in 1: reset, asynchronous and active-low.
- `txn_start` in 1: request strobe; sampled only in IDLE.
- `txn_is_in` in 1: 1 = IN transaction, 0 = OUT transaction; captured with `txn_start`.
- `txn_addr` in 7: device address; captured with `txn_start`.
- `txn_endp` in 4: endpoint number; captured with `txn_start`.
- `txn_wdata` in 64: OUT payload; captured with `txn_start`.
- `busy` out 1: transaction in progress.
- `txn_done` out 1: one-cycle completion pulse.
- `txn_ok` out 1: valid with `txn_done`; 1 = success.
- `txn_rdata` out 64: IN payload; valid with `txn_done` when `txn_ok` = 1.
- `pid` out 4, `endp` out 4, `addr` out 7, `data` out 64, `pkttype` out 1: packet fields to `pipeOut`. `pkttype` 0 = token/handshake, 1 = data.
- `pktready_bs` out 1: one-cycle launch strobe to `pipeOut`.
- `down_ready` in 1, `sending_usb` in 1: status from `pipeOut`.
- `rx_data` in 64, `rx_pktready` in 1, `rx_error` in 1, `rx_ack` in 1, `rx_nak` in 1, `inpipe_recving` in 1: status from `pipeIn`.

## Operation

PID encodings:

- OUT = 4'b0001, IN = 4'b1001, DATA0 = 4'b0011, ACK = 4'b0010, NAK = 4'b1010.

States: IDLE, TOK, TOK_WAIT, DATA, DATA_WAIT, RESP, HS, HS_WAIT, FIN.

- IDLE: `txn_start` = 1 latches the request, clears the attempt counter, and goes to TOK. A `txn_start` outside IDLE is ignored.
- TOK: drive `pid` = OUT or IN, `addr`, `endp`, `pkttype` = 0.
  - Launch when `down_ready` = 1 and `sending_usb` = 0, then go to TOK_WAIT.
- TOK_WAIT: wait until `sending_usb` has been seen 1 and then returns to 0.
  - OUT transaction: go to DATA.
  - IN transaction: go to RESP.
- DATA: drive `pid` = DATA0, `data` = latched wdata, `pkttype` = 1. Launch with the same rule as TOK, then go to DATA_WAIT.
- DATA_WAIT: same completion rule as TOK_WAIT, then go to RESP.
- RESP (OUT transaction), priority `rx_error` > `rx_ack` > `rx_nak`:
  - `rx_ack`: success, go to FIN.
  - `rx_nak`, `rx_error` or timeout: failed attempt.
- RESP (IN transaction):
  - `rx_pktready` with `rx_error` = 0: latch `rx_data` into `txn_rdata` and send ACK via HS.
  - `rx_error` or timeout: send NAK via HS; the attempt is failed.
  - `rx_nak` from the device: failed attempt, no handshake is sent.
- HS: drive `pid` = ACK or NAK, `pkttype` = 0, then launch.
- HS_WAIT: on completion, go to FIN if ACK was sent, otherwise treat as a failed attempt.
- Failed attempt: increment the attempt counter.
  - If the count is now `MAX_RETRY`, go to FIN with failure.
  - Otherwise go to TOK.
- FIN: `txn_done` = 1 for one cycle, then go to IDLE.
- Events on `pipeIn` outputs outside RESP are ignored.

Timeout counter:

- Width $clog2(TIMEOUT+1).
- Cleared on entry to RESP.
- Increments each RESP cycle in which `inpipe_recving` = 0; holds while `inpipe_recving` = 1.
- Timeout fires when the count reaches `TIMEOUT`.

Attempt counter:

- Width $clog2(MAX_RETRY+1); it never wraps.

## Timing

- Reset values: all outputs are 0, the state is IDLE, and both counters are 0. `rst_L` low mid-transaction aborts immediately with no `txn_done`.
- IDLE → TOK latency: 1 cycle after `txn_start`. `busy` is 1 from that cycle through FIN inclusive.
- Launch: `pktready_bs` is registered high for exactly 1 cycle in the cycle after the launch condition.
- Packet fields: all packet fields are stable from one cycle before `pktready_bs` until the packet completes (`sending_usb` falls).
- Back-to-back packets: the next launch occurs at the earliest one cycle after `sending_usb` falls and `down_ready` = 1.
- `txn_ok`/`txn_rdata`: held from the FIN cycle until the next `txn_start` is accepted.

## Test plan

- OUT, addr 5, endp 4, wdata 64'hDEADBEEF_01234567, device ACKs → OUT token then DATA0 sent; `txn_done` with `txn_ok` = 1 on the first attempt.
- OUT, device NAKs twice then ACKs → 3 OUT+DATA0 sequences; `txn_ok` = 1.
- OUT, device silent → each attempt times out after 255 idle cycles; after 8 attempts `txn_done` with `txn_ok` = 0.
- OUT, `inpipe_recving` held high for 300 cycles inside RESP, then `rx_ack` → no timeout fires; `txn_ok` = 1.
- IN, first response has `rx_error` = 1, second is a clean packet with `rx_data` = 64'h0011223344556677 → NAK sent, second attempt sends ACK; `txn_rdata` = 64'h0011223344556677 and `txn_ok` = 1.
- `rst_L` pulled low during DATA_WAIT → next cycle all outputs are 0 and the state is IDLE; a new `txn_start` runs normally.

Source files
------------

// File: rtl/usb_protocol.sv
`timescale 1ns/1ps
`default_nettype none
// usb_protocol: host-side USB transaction engine that sequences token, DATA0 and
// handshake packets, with a per-attempt response timeout and bounded retry.
module usb_protocol #(
  parameter int MAX_RETRY = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst_L,
  input  logic        txn_start,
  input  logic        txn_is_in,
  input  logic [6:0]  txn_addr,
  input  logic [3:0]  txn_endp,
  input  logic [63:0] txn_wdata,
  output logic        busy,
  output logic        txn_done,
  output logic        txn_ok,
  output logic [63:0] txn_rdata,
  output logic [3:0]  pid,
  output logic [3:0]  endp,
  output logic [6:0]  addr,
  output logic [63:0] data,
  output logic        pkttype,
  output logic        pktready_bs,
  input  logic        down_ready,
  input  logic        sending_usb,
  input  logic [63:0] rx_data,
  input  logic        rx_pktready,
  input  logic        rx_error,
  input  logic        rx_ack,
  input  logic        rx_nak,
  input  logic        inpipe_recving
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int ATT_W = $clog2(MAX_RETRY + 1);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  typedef enum logic [3:0] {
    S_IDLE, S_TOK, S_TOK_WAIT, S_DATA, S_DATA_WAIT, S_RESP, S_HS, S_HS_WAIT, S_FIN
  } state_e;

  state_e             state_q, state_d;
  logic               is_in_q, is_in_d;
  logic               hs_ack_q, hs_ack_d;
  logic               seen_q, seen_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [ATT_W-1:0]   att_q, att_d;
  logic [3:0]         pid_q, pid_d;
  logic [6:0]         addr_q, addr_d;
  logic [3:0]         endp_q, endp_d;
  logic [63:0]        data_q, data_d;
  logic               pkttype_q, pkttype_d;
  logic               pkt_q, pkt_d;
  logic               ok_q, ok_d;
  logic [63:0]        rdata_q, rdata_d;

  logic launch, pkt_done, timeout, fail;

  assign launch   = down_ready && !sending_usb;
  // A packet is complete once sending_usb has been observed high and is low again.
  assign pkt_done = seen_q && !sending_usb;
  assign timeout  = (timer_q == TMR_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q   <= S_IDLE;
      is_in_q   <= 1'b0;
      hs_ack_q  <= 1'b0;
      seen_q    <= 1'b0;
      timer_q   <= '0;
      att_q     <= '0;
      pid_q     <= 4'b0;
      addr_q    <= 7'b0;
      endp_q    <= 4'b0;
      data_q    <= 64'b0;
      pkttype_q <= 1'b0;
      pkt_q     <= 1'b0;
      ok_q      <= 1'b0;
      rdata_q   <= 64'b0;
    end else begin
      state_q   <= state_d;
      is_in_q   <= is_in_d;
      hs_ack_q  <= hs_ack_d;
      seen_q    <= seen_d;
      timer_q   <= timer_d;
      att_q     <= att_d;
      pid_q     <= pid_d;
      addr_q    <= addr_d;
      endp_q    <= endp_d;
      data_q    <= data_d;
      pkttype_q <= pkttype_d;
      pkt_q     <= pkt_d;
      ok_q      <= ok_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    is_in_d   = is_in_q;
    hs_ack_d  = hs_ack_q;
    seen_d    = seen_q | sending_usb;
    timer_d   = timer_q;
    att_d     = att_q;
    pid_d     = pid_q;
    addr_d    = addr_q;
    endp_d    = endp_q;
    data_d    = data_q;
    pkttype_d = pkttype_q;
    pkt_d     = 1'b0;
    ok_d      = ok_q;
    rdata_d   = rdata_q;
    fail      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (txn_start) begin
          is_in_d   = txn_is_in;
          addr_d    = txn_addr;
          endp_d    = txn_endp;
          data_d    = txn_wdata;
          att_d     = '0;
          ok_d      = 1'b0;
          rdata_d   = 64'b0;
          pid_d     = txn_is_in ? PID_IN : PID_OUT;
          pkttype_d = 1'b0;
          state_d   = S_TOK;
        end
      end
      S_TOK, S_DATA, S_HS: begin
        if (launch) begin
          pkt_d  = 1'b1;
          seen_d = 1'b0;
          state_d = (state_q == S_TOK)  ? S_TOK_WAIT :
                    (state_q == S_DATA) ? S_DATA_WAIT : S_HS_WAIT;
        end
      end
      S_TOK_WAIT: begin
        if (pkt_done) begin
          if (is_in_q) begin
            timer_d = '0;
            state_d = S_RESP;
          end else begin
            pid_d     = PID_DATA0;
            pkttype_d = 1'b1;
            state_d   = S_DATA;
          end
        end
      end
      S_DATA_WAIT: begin
        if (pkt_done) begin
          timer_d = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (!inpipe_recving) timer_d = timer_q + TMR_W'(1);
        if (is_in_q) begin
          if (rx_error || (!rx_pktready && !rx_nak && timeout)) begin
            hs_ack_d  = 1'b0;
            pid_d     = PID_NAK;
            pkttype_d = 1'b0;
            state_d   = S_HS;
          end else if (rx_pktready) begin
            rdata_d   = rx_data;
            hs_ack_d  = 1'b1;
            pid_d     = PID_ACK;
            pkttype_d = 1'b0;
            state_d   = S_HS;
          end else if (rx_nak) begin
            fail = 1'b1;
          end
        end else begin
          if (rx_error) begin
            fail = 1'b1;
          end else if (rx_ack) begin
            ok_d    = 1'b1;
            state_d = S_FIN;
          end else if (rx_nak || timeout) begin
            fail = 1'b1;
          end
        end
      end
      S_HS_WAIT: begin
        if (pkt_done) begin
          if (hs_ack_q) begin
            ok_d    = 1'b1;
            state_d = S_FIN;
          end else begin
            fail = 1'b1;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Failed attempts either retry from the token or give up after MAX_RETRY tries.
    if (fail) begin
      att_d = att_q + ATT_W'(1);
      if (att_q == ATT_W'(MAX_RETRY - 1)) begin
        state_d = S_FIN;
      end else begin
        pid_d     = is_in_q ? PID_IN : PID_OUT;
        pkttype_d = 1'b0;
        state_d   = S_TOK;
      end
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign txn_done    = (state_q == S_FIN);
  assign txn_ok      = ok_q;
  assign txn_rdata   = rdata_q;
  assign pid         = pid_q;
  assign addr        = addr_q;
  assign endp        = endp_q;
  assign data        = data_q;
  assign pkttype     = pkttype_q;
  assign pktready_bs = pkt_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_protocol.sv
`timescale 1ns/1ps
`default_nettype none
// tb_usb_protocol: directed bench for usb_protocol with a behavioural pipeOut
// model (3-cycle packets) and scripted device responses.
module tb_usb_protocol;

  logic        clk = 1'b0;
  logic        rst_L = 1'b1;
  logic        txn_start, txn_is_in;
  logic [6:0]  txn_addr;
  logic [3:0]  txn_endp;
  logic [63:0] txn_wdata;
  logic        busy, txn_done, txn_ok;
  logic [63:0] txn_rdata;
  logic [3:0]  pid, endp;
  logic [6:0]  addr;
  logic [63:0] data;
  logic        pkttype, pktready_bs;
  logic        down_ready, sending_usb;
  logic [63:0] rx_data;
  logic        rx_pktready, rx_error, rx_ack, rx_nak, inpipe_recving;

  localparam logic [3:0] P_OUT = 4'b0001, P_IN = 4'b1001, P_D0 = 4'b0011;
  localparam logic [3:0] P_ACK = 4'b0010, P_NAK = 4'b1010;

  typedef struct packed {
    logic [3:0]  p;
    logic        t;
    logic [6:0]  a;
    logic [3:0]  e;
    logic [63:0] d;
    int          c;
  } pkt_t;

  pkt_t log_q[$];
  int   fall_cyc[$];
  int   end_cnt  = 0;
  int   cyc      = 0;
  int   epoch    = 0;
  int   done_cnt = 0;
  int   errors   = 0;
  int   checks   = 0;

  usb_protocol #(.MAX_RETRY(8), .TIMEOUT(255)) dut (
    .clk(clk), .rst_L(rst_L),
    .txn_start(txn_start), .txn_is_in(txn_is_in), .txn_addr(txn_addr),
    .txn_endp(txn_endp), .txn_wdata(txn_wdata),
    .busy(busy), .txn_done(txn_done), .txn_ok(txn_ok), .txn_rdata(txn_rdata),
    .pid(pid), .endp(endp), .addr(addr), .data(data), .pkttype(pkttype),
    .pktready_bs(pktready_bs), .down_ready(down_ready), .sending_usb(sending_usb),
    .rx_data(rx_data), .rx_pktready(rx_pktready), .rx_error(rx_error),
    .rx_ack(rx_ack), .rx_nak(rx_nak), .inpipe_recving(inpipe_recving)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (txn_done === 1'b1) done_cnt <= done_cnt + 1;

  // pipeOut model: each launch occupies the link for 3 cycles.
  initial begin : pipeout_model
    pkt_t cur;
    int   ep;
    sending_usb = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (pktready_bs === 1'b1) begin
        cur = '{p: pid, t: pkttype, a: addr, e: endp, d: data, c: cyc};
        ep  = epoch;
        log_q.push_back(cur);
        sending_usb = 1'b1;
        @(posedge clk); #1;
        if (ep == epoch) begin
          checks++;
          if (pktready_bs !== 1'b0) begin errors++; $display("FAIL pktready_width: got %b expected 0", pktready_bs); end
        end
        repeat (2) @(posedge clk); #1;
        if (ep == epoch) begin
          checks++;
          if ({pid, pkttype, addr, endp, data} !== {cur.p, cur.t, cur.a, cur.e, cur.d}) begin
            errors++; $display("FAIL field_stable: pid=%h type=%b addr=%h endp=%h expected pid=%h type=%b addr=%h endp=%h", pid, pkttype, addr, endp, cur.p, cur.t, cur.a, cur.e);
          end
        end
        sending_usb = 1'b0;
        fall_cyc.push_back(cyc);
        end_cnt++;
      end
    end
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    log_q.delete();
    fall_cyc.delete();
    end_cnt = 0;
  endtask

  task automatic start_txn(input logic is_in, input logic [6:0] a, input logic [3:0] e, input logic [63:0] w);
    @(negedge clk);
    txn_start = 1'b1; txn_is_in = is_in; txn_addr = a; txn_endp = e; txn_wdata = w;
    @(negedge clk);
    txn_start = 1'b0;
  endtask

  task automatic wait_ends(input int n, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (end_cnt >= n) begin hit = 1'b1; break; end
      @(posedge clk); #2;
    end
  endtask

  task automatic pulse_rx(input logic err, input logic ack, input logic nak, input logic pr, input logic [63:0] d);
    @(posedge clk); #2;
    rx_error = err; rx_ack = ack; rx_nak = nak; rx_pktready = pr; rx_data = d;
    @(posedge clk); #2;
    rx_error = 1'b0; rx_ack = 1'b0; rx_nak = 1'b0; rx_pktready = 1'b0; rx_data = 64'h0;
  endtask

  task automatic wait_done(input int budget, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (txn_done === 1'b1) begin hit = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    txn_start = 0; txn_is_in = 0; txn_addr = 0; txn_endp = 0; txn_wdata = 0;
    down_ready = 1; rx_data = 0; rx_pktready = 0; rx_error = 0; rx_ack = 0; rx_nak = 0; inpipe_recving = 0;
    #1 rst_L = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({busy, txn_done, txn_ok, pktready_bs, pkttype} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {busy, txn_done, txn_ok, pktready_bs, pkttype}); end
    checks++; if ({pid, endp, addr} !== 15'b0) begin errors++; $display("FAIL reset_fields: got %h expected 0", {pid, endp, addr}); end
    checks++; if ({data, txn_rdata} !== 128'b0) begin errors++; $display("FAIL reset_buses: got %h expected 0", {data, txn_rdata}); end
    rst_L = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_out_ack();
    bit hit;
    clear_logs();
    start_txn(1'b0, 7'd5, 4'd4, 64'hDEADBEEF_01234567);
    checks++; if ({busy, pid, pkttype} !== {1'b1, P_OUT, 1'b0}) begin errors++; $display("FAIL out_tok_entry: got busy/pid/type %b/%h/%b expected 1/1/0", busy, pid, pkttype); end
    @(negedge clk);
    checks++; if (pktready_bs !== 1'b1) begin errors++; $display("FAIL out_launch_latency: got %b expected 1", pktready_bs); end
    wait_ends(2, hit);
    checks++; if (!hit) begin errors++; $display("FAIL out_pkts_wait: got %0d packets expected 2", end_cnt); end
    pulse_rx(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    wait_done(50, hit);
    checks++; if (!hit) begin errors++; $display("FAIL out_done_wait: no txn_done expected one"); end
    checks++; if (txn_ok !== 1'b1) begin errors++; $display("FAIL out_ok: got %b expected 1", txn_ok); end
    checks++; if (log_q.size() != 2) begin errors++; $display("FAIL out_pkt_count: got %0d expected 2", log_q.size()); end
    checks++; if ({log_q[0].p, log_q[0].t, log_q[0].a, log_q[0].e} !== {P_OUT, 1'b0, 7'd5, 4'd4}) begin errors++; $display("FAIL out_token: got pid %h type %b addr %0d endp %0d expected 1 0 5 4", log_q[0].p, log_q[0].t, log_q[0].a, log_q[0].e); end
    checks++; if ({log_q[1].p, log_q[1].t, log_q[1].d} !== {P_D0, 1'b1, 64'hDEADBEEF_01234567}) begin errors++; $display("FAIL out_data0: got pid %h type %b data %h expected 3 1 deadbeef01234567", log_q[1].p, log_q[1].t, log_q[1].d); end
    checks++; if (log_q[1].c - fall_cyc[0] != 2) begin errors++; $display("FAIL b2b_gap: got %0d cycles expected 2", log_q[1].c - fall_cyc[0]); end
    @(negedge clk);
    checks++; if ({txn_done, busy, txn_ok} !== 3'b001) begin errors++; $display("FAIL out_after_fin: got done/busy/ok %b expected 001", {txn_done, busy, txn_ok}); end
  endtask

  task automatic test_out_nak_retry();
    bit hit;
    clear_logs();
    start_txn(1'b0, 7'h12, 4'h3, 64'h1);
    wait_ends(2, hit); pulse_rx(1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
    wait_ends(4, hit); pulse_rx(1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
    wait_ends(6, hit);
    checks++; if (!hit) begin errors++; $display("FAIL nak_pkts_wait: got %0d packets expected 6", end_cnt); end
    pulse_rx(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    wait_done(50, hit);
    checks++; if (!hit || txn_ok !== 1'b1) begin errors++; $display("FAIL nak_ok: got done %b ok %b expected 1 1", hit, txn_ok); end
    checks++; if (log_q.size() != 6) begin errors++; $display("FAIL nak_pkt_count: got %0d expected 6", log_q.size()); end
    checks++; if ({log_q[4].p, log_q[4].a, log_q[5].p} !== {P_OUT, 7'h12, P_D0}) begin errors++; $display("FAIL nak_third_attempt: got %h %h %h expected 1 12 3", log_q[4].p, log_q[4].a, log_q[5].p); end
  endtask

  task automatic test_out_timeout();
    bit hit;
    clear_logs();
    start_txn(1'b0, 7'd1, 4'd1, 64'h55);
    wait_done(4000, hit);
    checks++; if (!hit) begin errors++; $display("FAIL tmo_done_wait: no txn_done expected one"); end
    checks++; if (txn_ok !== 1'b0) begin errors++; $display("FAIL tmo_ok: got %b expected 0", txn_ok); end
    checks++; if (log_q.size() != 16) begin errors++; $display("FAIL tmo_pkt_count: got %0d expected 16", log_q.size()); end
    checks++; if (log_q[2].c - fall_cyc[1] != 258) begin errors++; $display("FAIL tmo_retry_latency: got %0d cycles expected 258", log_q[2].c - fall_cyc[1]); end
    checks++; if (log_q[15].p !== P_D0) begin errors++; $display("FAIL tmo_last_pkt: got %h expected 3", log_q[15].p); end
  endtask

  task automatic test_out_recving_hold();
    bit hit;
    clear_logs();
    start_txn(1'b0, 7'd9, 4'd2, 64'hA5A5);
    wait_ends(2, hit);
    inpipe_recving = 1'b1;
    repeat (300) @(posedge clk);
    #2;
    checks++; if (log_q.size() != 2) begin errors++; $display("FAIL recv_no_timeout: got %0d packets expected 2", log_q.size()); end
    inpipe_recving = 1'b0; rx_ack = 1'b1;
    @(posedge clk); #2;
    rx_ack = 1'b0;
    wait_done(20, hit);
    checks++; if (!hit || txn_ok !== 1'b1) begin errors++; $display("FAIL recv_ok: got done %b ok %b expected 1 1", hit, txn_ok); end
  endtask

  task automatic test_in_error_then_ok();
    bit hit;
    clear_logs();
    start_txn(1'b1, 7'h2A, 4'h7, 64'h0);
    checks++; if (pid !== P_IN) begin errors++; $display("FAIL in_tok_pid: got %h expected 9", pid); end
    wait_ends(1, hit);
    pulse_rx(1'b1, 1'b0, 1'b0, 1'b1, 64'hBAD0BAD0BAD0BAD0);
    @(negedge clk);
    txn_start = 1'b1; txn_is_in = 1'b0; txn_addr = 7'h7F;
    @(negedge clk);
    txn_start = 1'b0;
    wait_ends(3, hit);
    pulse_rx(1'b0, 1'b0, 1'b0, 1'b1, 64'h0011223344556677);
    wait_done(60, hit);
    checks++; if (!hit || txn_ok !== 1'b1) begin errors++; $display("FAIL in_ok: got done %b ok %b expected 1 1", hit, txn_ok); end
    checks++; if (txn_rdata !== 64'h0011223344556677) begin errors++; $display("FAIL in_rdata: got %h expected 0011223344556677", txn_rdata); end
    checks++; if (log_q.size() != 4) begin errors++; $display("FAIL in_pkt_count: got %0d expected 4", log_q.size()); end
    checks++; if ({log_q[0].p, log_q[1].p, log_q[2].p, log_q[3].p} !== {P_IN, P_NAK, P_IN, P_ACK}) begin errors++; $display("FAIL in_pid_seq: got %h %h %h %h expected 9 a 9 2", log_q[0].p, log_q[1].p, log_q[2].p, log_q[3].p); end
    checks++; if ({log_q[1].t, log_q[3].t, log_q[2].a, log_q[2].e} !== {1'b0, 1'b0, 7'h2A, 4'h7}) begin errors++; $display("FAIL in_hs_fields: got %b %b %h %h expected 0 0 2a 7", log_q[1].t, log_q[3].t, log_q[2].a, log_q[2].e); end
    repeat (5) @(negedge clk);
    checks++; if ({txn_ok, txn_rdata} !== {1'b1, 64'h0011223344556677}) begin errors++; $display("FAIL in_hold: got ok %b rdata %h expected 1 0011223344556677", txn_ok, txn_rdata); end
  endtask

  task automatic test_reset_abort();
    bit hit;
    int dc;
    clear_logs();
    start_txn(1'b0, 7'd3, 4'd2, 64'hCAFE);
    checks++; if ({txn_ok, txn_rdata} !== 65'b0) begin errors++; $display("FAIL accept_clears: got ok %b rdata %h expected 0 0", txn_ok, txn_rdata); end
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (log_q.size() >= 2) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL abort_data_wait: got %0d packets expected 2", log_q.size()); end
    dc = done_cnt;
    @(posedge clk); #3;
    epoch++;
    rst_L = 1'b0;
    @(negedge clk);
    checks++; if ({busy, txn_done, txn_ok, pktready_bs, pkttype, pid, addr, endp, data} !== 84'b0) begin errors++; $display("FAIL abort_outputs: got busy %b pid %h addr %h data %h expected all 0", busy, pid, addr, data); end
    @(negedge clk);
    rst_L = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (done_cnt != dc || busy !== 1'b0) begin errors++; $display("FAIL abort_no_done: got done pulses %0d busy %b expected %0d 0", done_cnt, busy, dc); end
    for (int i = 0; i < 20 && sending_usb; i++) @(negedge clk);
    clear_logs();
    start_txn(1'b0, 7'd3, 4'd2, 64'hCAFE);
    wait_ends(2, hit);
    pulse_rx(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    wait_done(50, hit);
    checks++; if (!hit || txn_ok !== 1'b1 || log_q.size() != 2) begin errors++; $display("FAIL abort_rerun: got done %b ok %b packets %0d expected 1 1 2", hit, txn_ok, log_q.size()); end
  endtask

  initial begin
    test_reset();
    test_out_ack();
    test_out_nak_retry();
    test_out_timeout();
    test_out_recving_hold();
    test_in_error_then_ok();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
